// File: rtl/fma_result_narrow_if.sv
// Stream bundle for fma_result_narrow: wide FMA results in, narrowed results out.
// slave = consumer of in_* / producer of out_*; master = the opposite side.
interface fma_result_narrow_if #(
  parameter int INTW  = 16,
  parameter int FRACW = 16
);
  logic                      in_valid;
  logic [INTW+2*FRACW-1:0]   in_data;
  logic                      almost_full;
  logic                      out_valid;
  logic                      out_ready;
  logic [INTW+FRACW-1:0]     out_data;
  logic                      out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output almost_full, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  almost_full, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fma_result_narrow.sv
// FMA result narrowing: FIFO, round-half-even to Q(INTW).(FRACW), saturate, valid/ready out.
// Ports: clk, rstn (async low), bus (slave), err_clr, ovf_err, occupancy, sat_count.
// Optional: FMA_NARROW_SATCNT_EN enables the saturating sat_count counter.
module fma_result_narrow #(
  parameter int INTW   = 16,
  parameter int FRACW  = 16,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  fma_result_narrow_if.slave       bus,
  input  logic                     err_clr,
  output logic                     ovf_err,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              sat_count
);

  localparam int W  = INTW + 2*FRACW;
  localparam int OW = INTW + FRACW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;
  logic          vld_q;
  logic [OW-1:0] dat_q;
  logic          sat_q;

  logic full, empty, push, pop, drop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && (!vld_q || bus.out_ready);
  // A full FIFO still accepts when the head leaves this cycle.
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
    end
  end

  // Round-half-even of the head, one guard bit above a sticky OR.
  logic [W-1:0]  x;
  logic [OW-1:0] q;
  logic          g, s, up;
  logic [OW:0]   r;
  logic          pos_ovf, neg_ovf;
  logic [OW-1:0] nd;
  logic          ns;

  always_comb begin
    x       = mem_q[rd_q];
    q       = x[W-1:FRACW];
    g       = x[FRACW-1];
    s       = |x[FRACW-2:0];
    up      = g & (s | q[0]);
    r       = {q[OW-1], q} + (OW+1)'(up);
    pos_ovf = !r[OW] &&  r[OW-1];
    neg_ovf =  r[OW] && !r[OW-1];
    nd      = r[OW-1:0];
    ns      = 1'b0;
    unique case (1'b1)
      pos_ovf: begin
        nd = {1'b0, {(OW-1){1'b1}}};
        ns = 1'b1;
      end
      neg_ovf: begin
        nd = {1'b1, {(OW-1){1'b0}}};
        ns = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      sat_q <= 1'b0;
    end else if (pop) begin
      vld_q <= 1'b1;
      dat_q <= nd;
      sat_q <= ns;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // A drop in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (err_clr) ovf_q <= 1'b0;
  end

`ifdef FMA_NARROW_SATCNT_EN
  logic [15:0] satc_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      satc_q <= '0;
    else if (vld_q && bus.out_ready && sat_q && satc_q != 16'hFFFF)
      satc_q <= satc_q + 16'd1;
  end
  assign sat_count = satc_q;
`else
  assign sat_count = '0;
`endif

  assign bus.almost_full = (DEPTH - int'(cnt_q)) <= AF_LVL;
  assign bus.out_valid   = vld_q;
  assign bus.out_data    = dat_q;
  assign bus.out_sat     = sat_q;
  assign ovf_err         = ovf_q;
  assign occupancy       = cnt_q;

endmodule
